fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Downstream drain stage for the 32-byte burst FIFO. It pulls bytes one at a time over the FIFO's valid/enable read handshake. Each byte is serialised onto a UART line as 8N1, or 8E1 when parity is enabled, LSB first. It also counts bytes so it can flag the end of each 32-byte burst, which is when the FIFO re-opens for writing.

## Interface
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- PARITY_EN, 0: 1 inserts an even-parity bit between the data bits and the stop bit.
- BURST_LEN, 32: bytes per FIFO burst; a power of two.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_valid  input  1  FIFO has a byte available (FIFO output_valid).
- fifo_enable  output  1  read request to the FIFO (FIFO output_enable); registered, one-cycle pulse.
- fifo_data  input  8  FIFO data_out; valid the cycle after fifo_enable.
- txd  output  1  serial line; idles high.
- busy  output  1  high from FETCH through the last STOP cycle.
- byte_done  output  1  one-cycle pulse at the end of each stop bit.
- burst_done  output  1  one-cycle pulse coincident with byte_done of the BURST_LEN-th byte.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: txd=1. If fifo_valid=1, go to FETCH; otherwise stay.
- FETCH: fifo_enable=1 for exactly this cycle. Go to LOAD.
- LOAD: capture fifo_data into an 8-bit shift register at the end of this cycle. Clear the bit index and the parity accumulator. Go to START.
- START: txd=0 for CLKS_PER_BIT cycles. Go to DATA.
- DATA: txd = shift[0]. Hold each bit for CLKS_PER_BIT cycles, then shift right. After bit index 7, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: txd = XOR of the 8 data bits, for CLKS_PER_BIT cycles.
- STOP: txd=1 for CLKS_PER_BIT cycles. The last cycle of STOP does the following:
  - pulse byte_done;
  - increment the burst counter (log2(BURST_LEN) bits);
  - on wrap to 0, pulse burst_done;
  - go to IDLE.
- fifo_valid is sampled only in IDLE. Changes in any other state are ignored.
- Bit counter width is clog2(CLKS_PER_BIT). It reloads at every state entry and wraps without overflow.
- Reset (asynchronous, takes effect immediately):
  - txd=1; fifo_enable, busy, byte_done and burst_done = 0;
  - state IDLE; all counters 0;
  - a byte in flight is discarded.

## Timing
- Cycle n: IDLE sees fifo_valid=1. Cycle n+1: fifo_enable=1. Cycle n+2: LOAD. Cycle n+3: first start-bit cycle.
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back bytes: 3 idle-high cycles (IDLE, FETCH, LOAD) between the end of STOP and the next START. Byte period is 10·CLKS_PER_BIT+3 cycles.
- byte_done and burst_done are registered and high for exactly one cycle.
- No combinational path from fifo_valid to fifo_enable.

## Structure
- Shared package `uart_pkg`: state enum; default constant for CLKS_PER_BIT; TXD_IDLE=1'b1; the burst length constant, shared with the FIFO.
- One sub-module, `uart_baud_tick`: a bit-period counter with a reload input and a one-cycle tick output at count CLKS_PER_BIT-1.
- The FSM, shift register, parity accumulator and burst counter live in the top.

## Test plan
- Reset: assert rst mid-idle -> txd=1, fifo_enable=0, busy=0, byte_done=0, burst_done=0 in the same cycle.
- CLKS_PER_BIT=4, PARITY_EN=0, FIFO model supplying 0xA5:
  - fifo_enable high for 1 cycle; start bit 2 cycles later;
  - txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles;
  - byte_done on the 40th frame cycle.
- PARITY_EN=1, byte 0x07 -> txd = 0,1,1,1,0,0,0,0,0, parity 1, stop 1; 44-cycle frame.
- Full burst from the FIFO model with bytes 0x00..0x1F, CLKS_PER_BIT=4:
  - 32 fifo_enable pulses, spaced 43 cycles apart;
  - burst_done exactly once, with the 32nd byte_done;
  - burst counter reads 0 afterwards.
- fifo_valid low in IDLE -> no fifo_enable, txd stays 1. fifo_valid toggled during DATA -> frame unaffected, no extra read.
- rst pulsed during data bit 3:
  - txd=1 immediately and the partial frame is dropped;
  - after release with fifo_valid=1, a fresh fetch occurs;
  - the burst count restarts at 0, so burst_done arrives after 32 more bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the burst-FIFO UART drain stage.
//   state_t          - transmitter FSM states
//   CLKS_PER_BIT_DEF - default bit period (100 MHz / 115200)
//   TXD_IDLE         - idle / stop level of the serial line
//   FIFO_BURST_LEN   - bytes per FIFO burst, shared with the FIFO
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int   CLKS_PER_BIT_DEF = 868;
  localparam logic TXD_IDLE         = 1'b1;
  localparam int   FIFO_BURST_LEN   = 32;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter.
//   clk, rst  - clock, async active-high reset
//   reload    - restart the period (counter reads 0 next cycle)
//   tick      - registered, high while the count is CLKS_PER_BIT-1
//   tick_pre  - combinational, high one cycle before tick (count
//               CLKS_PER_BIT-2 with no reload); lets callers register
//               outputs that must line up with tick
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick,
  output logic tick_pre
);

  localparam int              CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  assign tick_pre = !reload && (cnt == PRE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      // tick is the registered form of "next count is LAST"
      tick <= tick_pre;
      if (reload || cnt == LAST) cnt <= '0;
      else                       cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the burst FIFO one byte at a time and serialises
// each byte as 8N1 (or 8E1 with PARITY_EN), LSB first.
//   clk, rst     - clock, async active-high reset
//   fifo_valid   - FIFO has a byte (sampled only in IDLE)
//   fifo_enable  - registered one-cycle read request
//   fifo_data    - FIFO read data, valid the cycle after fifo_enable
//   txd          - serial line, idles high
//   busy         - high from FETCH through the last STOP cycle
//   byte_done    - one-cycle pulse on the last STOP cycle
//   burst_done   - byte_done of every BURST_LEN-th byte
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit PARITY_EN    = 1'b0,
  parameter int BURST_LEN    = FIFO_BURST_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_valid,
  output logic       fifo_enable,
  input  logic [7:0] fifo_data,
  output logic       txd,
  output logic       busy,
  output logic       byte_done,
  output logic       burst_done
);

  localparam int            BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BURST_LEN - 1);

  state_t        st, st_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [2:0]    idx, idx_nxt;
  logic          par, par_nxt;
  logic          txd_nxt;
  logic [BW-1:0] burst_cnt;
  logic          tick, tick_pre, reload;

  // Every state entry restarts the bit period; IDLE keeps it parked.
  assign reload = (st_nxt != st) || (st == S_IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .reload   (reload),
    .tick     (tick),
    .tick_pre (tick_pre)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    shift_nxt = shift;
    idx_nxt   = idx;
    par_nxt   = par;
    case (st)
      S_IDLE:   if (fifo_valid) st_nxt = S_FETCH;
      S_FETCH:  st_nxt = S_LOAD;
      S_LOAD: begin
        shift_nxt = fifo_data;
        idx_nxt   = '0;
        par_nxt   = 1'b0;
        st_nxt    = S_START;
      end
      S_START:  if (tick) st_nxt = S_DATA;
      S_DATA: begin
        if (tick) begin
          shift_nxt = {1'b0, shift[7:1]};
          par_nxt   = par ^ shift[0];
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) st_nxt = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (tick) st_nxt = S_STOP;
      S_STOP:   if (tick) st_nxt = S_IDLE;
      default:  st_nxt = S_IDLE;
    endcase

    // txd is registered from next-state values so the line never glitches
    case (st_nxt)
      S_START:  txd_nxt = 1'b0;
      S_DATA:   txd_nxt = shift_nxt[0];
      S_PARITY: txd_nxt = par_nxt;
      default:  txd_nxt = TXD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift       <= '0;
      idx         <= '0;
      par         <= 1'b0;
      txd         <= TXD_IDLE;
      fifo_enable <= 1'b0;
      busy        <= 1'b0;
      byte_done   <= 1'b0;
      burst_done  <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      shift       <= shift_nxt;
      idx         <= idx_nxt;
      par         <= par_nxt;
      txd         <= txd_nxt;
      fifo_enable <= (st_nxt == S_FETCH);
      busy        <= (st_nxt != S_IDLE);
      // Armed one cycle early so the pulses land on the last STOP cycle.
      byte_done   <= (st == S_STOP) && tick_pre;
      burst_done  <= (st == S_STOP) && tick_pre && (burst_cnt == BLAST);
      if (st == S_STOP && tick) burst_cnt <= burst_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: FIFO model + UART receiver scoreboard around two
// fifo_uart_tx instances (8N1 and 8E1), CLKS_PER_BIT = 4.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int PERIOD = 10 * CPB + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fifo_valid = 2'b00;
  logic [1:0] fifo_enable, txd, busy, byte_done, burst_done;
  logic [7:0] fifo_data [2];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .BURST_LEN(32)) dut (
    .clk(clk), .rst(rst), .fifo_valid(fifo_valid[0]), .fifo_enable(fifo_enable[0]),
    .fifo_data(fifo_data[0]), .txd(txd[0]), .busy(busy[0]),
    .byte_done(byte_done[0]), .burst_done(burst_done[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .BURST_LEN(32)) dut_p (
    .clk(clk), .rst(rst), .fifo_valid(fifo_valid[1]), .fifo_enable(fifo_enable[1]),
    .fifo_data(fifo_data[1]), .txd(txd[1]), .busy(busy[1]),
    .byte_done(byte_done[1]), .burst_done(burst_done[1]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] src0[$], src1[$], exp0[$], exp1[$];

  // FIFO model: serves a byte the cycle after each read request and
  // pushes it to the scoreboard.
  int cyc = 0;
  int last_fetch = -1;
  bit chk_space = 1'b0;
  int n_fetch [2] = '{0, 0};

  always @(posedge clk) begin : fifo_model
    logic [7:0] b;
    int avail;
    cyc++;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (fifo_enable[i]) begin
          n_fetch[i]++;
          if (i == 0) begin
            if (chk_space && last_fetch >= 0) chk("fetch_space", cyc - last_fetch, PERIOD);
            last_fetch = cyc;
          end
          avail = (i == 0) ? src0.size() : src1.size();
          if (avail == 0) chk("read_empty", fifo_enable[i], 1'b0);
          else begin
            if (i == 0) begin b = src0.pop_front(); exp0.push_back(b); end
            else        begin b = src1.pop_front(); exp1.push_back(b); end
            fifo_data[i] <= b;
          end
        end
      end
    end
  end

  // UART receiver: decodes each frame, checks it against the scoreboard,
  // and checks byte_done / burst_done placement.
  bit         rx_act [2];
  int         rx_cyc [2];
  int         rx_frames [2];
  int         n_burst [2] = '{0, 0};
  logic [10:0] rx_bits [2];

  always @(negedge clk) begin : rx
    int nb;
    logic [7:0] d, e;
    bit last;
    for (int i = 0; i < 2; i++) begin
      nb = (i == 1) ? 11 : 10;
      if (rst) begin
        rx_act[i]    = 1'b0;
        rx_frames[i] = 0;
      end else begin
        if (!rx_act[i] && txd[i] == 1'b0) begin
          rx_act[i] = 1'b1;
          rx_cyc[i] = 0;
        end
        last = rx_act[i] && (rx_cyc[i] == nb * CPB - 1);
        if (byte_done[i] || burst_done[i] || last) begin
          chk("rx_byte_done", byte_done[i], last);
          if (byte_done[i]) begin
            rx_frames[i]++;
            chk("rx_burst_done", burst_done[i], (rx_frames[i] % 32) == 0);
          end else chk("rx_burst_stray", burst_done[i], 1'b0);
          if (burst_done[i]) n_burst[i]++;
        end
        if (rx_act[i]) begin
          if (rx_cyc[i] % CPB == 1) rx_bits[i][rx_cyc[i] / CPB] = txd[i];
          if (last) begin
            rx_act[i] = 1'b0;
            d = rx_bits[i][8:1];
            chk("rx_start", rx_bits[i][0], 1'b0);
            chk("rx_stop", rx_bits[i][nb-1], 1'b1);
            if (i == 1) chk("rx_parity", rx_bits[i][9], ^d);
            if ((i == 0 ? exp0.size() : exp1.size()) == 0) chk("rx_unexpected", 1, 0);
            else begin
              e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
              chk("rx_data", d, e);
            end
          end else rx_cyc[i]++;
        end
      end
    end
  end

  // Directed single frame with bit-exact txd timing. With tog set,
  // fifo_valid chatters through the data bits and must be ignored.
  task automatic frame(input int i, input logic [7:0] b, input bit tog);
    int nb;
    logic [10:0] bits;
    nb = (i == 1) ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    if (i == 1) bits[9] = ^b;
    if (i == 0) src0.push_back(b); else src1.push_back(b);
    @(negedge clk); fifo_valid[i] = 1'b1;
    @(negedge clk);
    chk("fetch_en", fifo_enable[i], 1'b1);
    chk("fetch_busy", busy[i], 1'b1);
    fifo_valid[i] = 1'b0;
    @(negedge clk);
    chk("load_en", fifo_enable[i], 1'b0);
    chk("load_txd", txd[i], 1'b1);
    for (int k = 0; k < nb * CPB; k++) begin
      @(negedge clk);
      chk("frame_txd", txd[i], bits[k / CPB]);
      chk("frame_byte_done", byte_done[i], k == nb * CPB - 1);
      if (tog) fifo_valid[i] = (k >= 8 && k < 30) ? k[0] : 1'b0;
    end
    @(negedge clk);
    chk("post_txd", txd[i], 1'b1);
    chk("post_busy", busy[i], 1'b0);
    chk("post_byte_done", byte_done[i], 1'b0);
  endtask

  initial begin : main
    int f0, t;
    logic [1:0] en_seen, txd_and;

    // reset held from time 0
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 2'b11);
    chk("rst_en", fifo_enable, 2'b00);
    chk("rst_busy", busy, 2'b00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset asserted mid-idle: outputs immediately at reset values
    #2 rst = 1'b1;
    #1;
    chk("rst_idle_txd", txd, 2'b11);
    chk("rst_idle_en", fifo_enable, 2'b00);
    chk("rst_idle_busy", busy, 2'b00);
    chk("rst_idle_done", {byte_done, burst_done}, 4'b0000);
    @(negedge clk); rst = 1'b0;

    frame(0, 8'hA5, 1'b0);
    frame(1, 8'h07, 1'b0);

    // fifo_valid low in IDLE: no reads, line stays high
    en_seen = '0;
    txd_and = '1;
    repeat (20) begin
      @(negedge clk);
      en_seen |= fifo_enable;
      txd_and &= txd;
    end
    chk("idle_no_fetch", en_seen, 2'b00);
    chk("idle_txd", txd_and, 2'b11);

    // fifo_valid chatter during the frame: one read only
    f0 = n_fetch[0];
    frame(0, 8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    chk("toggle_one_read", n_fetch[0] - f0, 1);

    // reset during data bit 3 of 0xF0 (bit 3 is 0 on the line)
    src0.push_back(8'hF0);
    @(negedge clk); fifo_valid[0] = 1'b1;
    @(negedge clk); fifo_valid[0] = 1'b0;
    @(negedge clk);
    for (int k = 0; k <= 17; k++) @(negedge clk);
    chk("bit3_txd", txd[0], 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_txd", txd[0], 1'b1);
    chk("rst_mid_busy", busy[0], 1'b0);
    exp0.delete();
    @(negedge clk);
    @(negedge clk);

    // full burst 0x00..0x1F right after release
    for (int b = 0; b < 32; b++) src0.push_back(8'(b));
    f0 = n_fetch[0];
    last_fetch = -1;
    chk_space = 1'b1;
    fifo_valid[0] = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("fresh_fetch", fifo_enable[0], 1'b1);
    t = 0;
    while (rx_frames[0] < 32 && t < 32 * PERIOD + 200) begin
      fifo_valid[0] = (src0.size() != 0);
      @(negedge clk);
      t++;
    end
    fifo_valid[0] = 1'b0;
    chk_space = 1'b0;
    chk("burst_frames", rx_frames[0], 32);
    chk("burst_fetches", n_fetch[0] - f0, 32);
    chk("burst_once", n_burst[0], 1);
    chk("burst_cnt_wrap", dut.burst_cnt, 0);
    chk("scoreboard_drained", exp0.size() + exp1.size(), 0);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
